// File: rtl/i2s_pkg.sv
// Shared types and helpers for the multi-channel I2S/TDM transmitter.
package i2s_pkg;

  // Serial framing: standard I2S (one-bit data delay) or left-justified.
  typedef enum logic [0:0] {
    I2S_STD = 1'b0,
    I2S_LJ  = 1'b1
  } i2s_mode_e;

  // Number of bit clocks in one complete frame.
  function automatic int frame_bits(input int slot_w, input int num_ch);
    return slot_w * num_ch;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock generator: divides clk into bclk_o and flags the clk cycle
// in which bclk_o is about to rise or fall.
module i2s_clk_div #(
  parameter int BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  assign wrap   = en_i && (cnt_q == DIV_W'(BCLK_DIV - 1));
  assign bclk_o = bclk_q;
  assign rise_o = wrap && !bclk_q;
  assign fall_o = wrap && bclk_q;

  // Half-period counter; bclk toggles on wrap, everything parks at 0 when disabled.
  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx_multi.sv
// Multi-channel I2S/TDM transmitter: one-frame holding buffer, frame
// shift register, bit counter and frame-sync generation.
module i2s_tx_multi
  import i2s_pkg::*;
#(
  parameter int        DATA_W   = 24,
  parameter int        SLOT_W   = 32,
  parameter int        NUM_CH   = 2,
  parameter int        BCLK_DIV = 2,
  parameter i2s_mode_e MODE     = I2S_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     bclk_o,
  output logic                     lrclk_o,
  output logic                     sdata_o,
  output logic                     frame_o,
  output logic                     underrun_o,
  input  logic                     underrun_clr_i
);

  localparam int FRAME_BITS = frame_bits(SLOT_W, NUM_CH);
  localparam int HALF_BITS  = FRAME_BITS / 2;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  logic                     fall;
  logic                     rise_unused;
  logic                     load;
  logic                     xfer;
  logic                     cur_bit;
  logic [FRAME_BITS-1:0]    fmt;
  logic [FRAME_BITS-1:0]    src;

  logic [NUM_CH*DATA_W-1:0] buf_q, buf_d;
  logic                     full_q, full_d;
  logic [FRAME_BITS-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     lrclk_q, lrclk_d;
  logic                     sdata_q, sdata_d;
  logic                     dly_q, dly_d;
  logic                     frame_q, frame_d;
  logic                     underrun_q, underrun_d;

  // All serial outputs move on the falling strobe, so the rise strobe is not needed here.
  i2s_clk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .bclk_o (bclk_o),
    .rise_o (rise_unused),
    .fall_o (fall)
  );

  assign load       = fall && (cnt_q == '0);
  assign xfer       = valid_i && !full_q;
  assign src        = load ? fmt : shreg_q;
  assign cur_bit    = src[FRAME_BITS-1];
  assign ready_o    = !full_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign frame_o    = frame_q;
  assign underrun_o = underrun_q;

  // Lay the buffered channels out as MSB-first slots, zero-padded; an empty buffer sends silence.
  always_comb begin
    fmt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fmt[FRAME_BITS-1-c*SLOT_W -: DATA_W] = full_q ? buf_q[c*DATA_W +: DATA_W] : '0;
    end
  end

  // Next-state for serialiser, frame sync, holding buffer and underrun flag.
  always_comb begin
    buf_d      = buf_q;
    full_d     = full_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    dly_d      = dly_q;
    underrun_d = underrun_q;
    frame_d    = load;

    if (!en_i) begin
      cnt_d   = '0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      dly_d   = 1'b0;
    end else if (fall) begin
      shreg_d = src << 1;
      cnt_d   = (cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
      lrclk_d = (cnt_q >= CNT_W'(HALF_BITS));
      if (MODE == I2S_STD) begin
        sdata_d = dly_q;
        dly_d   = cur_bit;
      end else begin
        sdata_d = cur_bit;
      end
    end

    if (load) full_d = 1'b0;
    if (xfer) begin
      full_d = 1'b1;
      buf_d  = data_i;
    end

    if (underrun_clr_i) underrun_d = 1'b0;
    if (load && !full_q) underrun_d = 1'b1;
  end

  // State registers; reset drops both the buffered frame and the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= '0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      dly_q      <= 1'b0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      full_q     <= full_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      dly_q      <= dly_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Directed bench: a default stereo I2S instance and a 4-channel
// left-justified TDM instance run in lock step (both have 64-bit frames).
module tb_i2s_tx_multi;
  import i2s_pkg::*;

  localparam int FRAME_CLKS = 256;
  localparam logic [63:0] LR_PATTERN = 64'h00000000_FFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        enI;
  logic        validI;
  logic        clrI;
  logic [47:0] dataStd;
  logic [63:0] dataLj;

  logic readyStd, bclkStd, lrclkStd, sdataStd, frameStd, underrunStd;
  logic readyLj, bclkLj, lrclkLj, sdataLj, frameLj, underrunLj;

  int vectors     = 0;
  int miscompares = 0;
  int extraPulses = 0;
  int waitN;

  logic [63:0] sdS, lrS, sdL, lrL, bhi;
  logic [23:0] frL [0:10];
  logic [23:0] frR [0:10];
  logic [63:0] frLj [0:10];
  logic [63:0] expS [0:10];

  always #5 clk = ~clk;

  i2s_tx_multi dut_std (
    .clk            (clk),
    .rst            (rst),
    .en_i           (enI),
    .data_i         (dataStd),
    .valid_i        (validI),
    .ready_o        (readyStd),
    .bclk_o         (bclkStd),
    .lrclk_o        (lrclkStd),
    .sdata_o        (sdataStd),
    .frame_o        (frameStd),
    .underrun_o     (underrunStd),
    .underrun_clr_i (clrI)
  );

  i2s_tx_multi #(
    .DATA_W   (16),
    .SLOT_W   (16),
    .NUM_CH   (4),
    .BCLK_DIV (2),
    .MODE     (I2S_LJ)
  ) dut_lj (
    .clk            (clk),
    .rst            (rst),
    .en_i           (enI),
    .data_i         (dataLj),
    .valid_i        (validI),
    .ready_o        (readyLj),
    .bclk_o         (bclkLj),
    .lrclk_o        (lrclkLj),
    .sdata_o        (sdataLj),
    .frame_o        (frameLj),
    .underrun_o     (underrunLj),
    .underrun_clr_i (clrI)
  );

  // Expected standard-I2S stream for one stereo frame: slots delayed by one bit.
  function automatic logic [63:0] stdExp(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] img;
    img = {l, 8'h00, r, 8'h00};
    return img >> 1;
  endfunction

  // Channel 0 sits in the top 16 bits of a TDM image but in the LSBs of data_i.
  function automatic logic [63:0] ljPack(input logic [63:0] img);
    return {img[15:0], img[31:16], img[47:32], img[63:48]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] dS, input logic [63:0] ljImg, input logic v);
    dataStd = dS;
    dataLj  = ljPack(ljImg);
    validI  = v;
  endtask

  // Counts falling clk edges until frame_o shows, giving up after a bound.
  task automatic waitFrame(output int n);
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (frameStd) break;
    end
  endtask

  // Starts in a frame_o cycle; samples every bit while bclk is high and optionally queues the next frame.
  task automatic captureFrame(input logic doPush, input logic [47:0] pS, input logic [63:0] pLj);
    sdS = '0; lrS = '0; sdL = '0; lrL = '0; bhi = '0;
    for (int off = 0; off < FRAME_CLKS; off++) begin
      if (off > 0) @(negedge clk);
      if (off > 0 && (frameStd || frameLj)) extraPulses++;
      if (doPush && off == 0) applyStimulus(pS, pLj, 1'b1);
      if (doPush && off == 1) begin
        applyStimulus(pS, pLj, 1'b0);
        checkOutput("ready_drop_std", 64'(readyStd), 64'd0);
        checkOutput("ready_drop_lj", 64'(readyLj), 64'd0);
      end
      if (off % 4 == 2) begin
        sdS[63 - off/4] = sdataStd;
        lrS[63 - off/4] = lrclkStd;
        sdL[63 - off/4] = sdataLj;
        lrL[63 - off/4] = lrclkLj;
        bhi[63 - off/4] = bclkStd & bclkLj;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 11; k++) begin
      frL[k]  = 24'hA5A5A5 ^ {3{8'(k)}};
      frR[k]  = 24'h5A5A5A ^ {3{8'(3 * k)}};
      frLj[k] = {16'h1234 + 16'(k), 16'h5678 + 16'(k), 16'h9ABC + 16'(k), 16'hDEF0 + 16'(k)};
      expS[k] = stdExp(frL[k], frR[k]);
    end
    expS[0] = 64'h52D2D280_2D2D2D00;

    rst = 1'b1; enI = 1'b0; clrI = 1'b0;
    applyStimulus('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_ready_std", 64'(readyStd), 64'd1);
    checkOutput("rst_ready_lj", 64'(readyLj), 64'd1);
    checkOutput("rst_outs_std", 64'({bclkStd, lrclkStd, sdataStd, frameStd, underrunStd}), 64'd0);
    checkOutput("rst_outs_lj", 64'({bclkLj, lrclkLj, sdataLj, frameLj, underrunLj}), 64'd0);
    rst = 1'b0;

    $display("[TB] load first frame while disabled");
    @(negedge clk);
    applyStimulus({frR[0], frL[0]}, frLj[0], 1'b1);
    @(negedge clk);
    applyStimulus({frR[0], frL[0]}, frLj[0], 1'b0);
    checkOutput("ready_full_std", 64'(readyStd), 64'd0);
    checkOutput("ready_full_lj", 64'(readyLj), 64'd0);

    enI = 1'b1;
    waitFrame(waitN);
    checkOutput("enable_latency", 64'(waitN), 64'd4);
    checkOutput("frame_lj_aligned", 64'(frameLj), 64'd1);
    checkOutput("ready_at_load", 64'({readyStd, readyLj}), 64'b11);
    checkOutput("no_underrun", 64'({underrunStd, underrunLj}), 64'b00);

    $display("[TB] ten back-to-back frames");
    for (int k = 0; k < 10; k++) begin
      captureFrame(k < 9, {frR[k+1], frL[k+1]}, frLj[k+1]);
      checkOutput($sformatf("std_data_f%0d", k), sdS, expS[k]);
      checkOutput($sformatf("std_lrclk_f%0d", k), lrS, LR_PATTERN);
      checkOutput($sformatf("lj_data_f%0d", k), sdL, frLj[k]);
      checkOutput($sformatf("lj_lrclk_f%0d", k), lrL, LR_PATTERN);
      checkOutput($sformatf("bclk_high_f%0d", k), bhi, '1);
      waitFrame(waitN);
      checkOutput($sformatf("frame_period_f%0d", k), 64'(waitN), 64'd1);
      checkOutput($sformatf("ready_rise_f%0d", k), 64'({readyStd, readyLj}), 64'b11);
    end
    checkOutput("extra_frame_pulses", 64'(extraPulses), 64'd0);

    $display("[TB] underrun frame and sticky flag");
    checkOutput("underrun_set", 64'({underrunStd, underrunLj}), 64'b11);
    captureFrame(1'b0, '0, '0);
    checkOutput("underrun_std_zero", sdS, 64'd0);
    checkOutput("underrun_lj_zero", sdL, 64'd0);
    checkOutput("underrun_sticky", 64'({underrunStd, underrunLj}), 64'b11);
    clrI = 1'b1;
    waitFrame(waitN);
    clrI = 1'b0;
    checkOutput("clr_frame_period", 64'(waitN), 64'd1);
    checkOutput("set_beats_clear", 64'({underrunStd, underrunLj}), 64'b11);
    @(negedge clk);
    clrI = 1'b1;
    @(negedge clk);
    clrI = 1'b0;
    checkOutput("underrun_cleared", 64'({underrunStd, underrunLj}), 64'b00);
    applyStimulus({24'h123456, 24'hC0FFEE}, 64'hBEEF_CAFE_0F0F_F00D, 1'b1);
    @(negedge clk);
    applyStimulus({24'h123456, 24'hC0FFEE}, 64'hBEEF_CAFE_0F0F_F00D, 1'b0);

    $display("[TB] disable at bit 17");
    waitFrame(waitN);
    checkOutput("frame12_wait", 64'(waitN), 64'd253);
    repeat (70) @(negedge clk);
    checkOutput("bit17_before_dis", 64'({bclkStd, sdataStd, bclkLj, sdataLj}), 64'b1111);
    enI = 1'b0;
    @(negedge clk);
    checkOutput("dis_outs_std", 64'({bclkStd, lrclkStd, sdataStd}), 64'd0);
    checkOutput("dis_outs_lj", 64'({bclkLj, lrclkLj, sdataLj}), 64'd0);
    applyStimulus({24'hFFFFFF, 24'h800001}, 64'h8001_7FFE_AAAA_5555, 1'b1);
    @(negedge clk);
    applyStimulus({24'hFFFFFF, 24'h800001}, 64'h8001_7FFE_AAAA_5555, 1'b0);
    checkOutput("dis_handshake", 64'({readyStd, readyLj}), 64'b00);
    repeat (20) @(negedge clk);
    checkOutput("dis_held", 64'({bclkStd, lrclkStd, sdataStd, frameStd, bclkLj, lrclkLj, sdataLj, frameLj}), 64'd0);
    enI = 1'b1;
    waitFrame(waitN);
    checkOutput("reenable_latency", 64'(waitN), 64'd4);
    checkOutput("reenable_lj_msb", 64'(sdataLj), 64'd1);
    captureFrame(1'b1, {24'h000F00, 24'h00F000}, 64'h1111_2222_3333_4444);
    checkOutput("reenable_std_data", sdS, stdExp(24'h800001, 24'hFFFFFF));
    checkOutput("reenable_lj_data", sdL, 64'h8001_7FFE_AAAA_5555);

    $display("[TB] reset mid-frame");
    waitFrame(waitN);
    checkOutput("frame_d_period", 64'(waitN), 64'd1);
    applyStimulus({24'h777777, 24'h333333}, 64'h5555_6666_7777_8888, 1'b1);
    @(negedge clk);
    applyStimulus({24'h777777, 24'h333333}, 64'h5555_6666_7777_8888, 1'b0);
    checkOutput("pre_rst_full", 64'({readyStd, readyLj}), 64'b00);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", 64'({readyStd, readyLj}), 64'b11);
    checkOutput("midrst_outs", 64'({bclkStd, lrclkStd, sdataStd, frameStd, underrunStd,
                                    bclkLj, lrclkLj, sdataLj, frameLj, underrunLj}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitFrame(waitN);
    checkOutput("post_rst_latency", 64'(waitN), 64'd4);
    checkOutput("post_rst_underrun", 64'({underrunStd, underrunLj}), 64'b11);
    captureFrame(1'b0, '0, '0);
    checkOutput("post_rst_std_zero", sdS, 64'd0);
    checkOutput("post_rst_lj_zero", sdL, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_multi.md
I2S_TX_MULTI -- requirements
Module: i2s_tx_multi

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits; legal range 8..32.
REQ-002 Parameter SLOT_W, default 32: bits per channel slot; SLOT_W >= DATA_W.
REQ-003 Parameter NUM_CH, default 2: channels per frame; even, 2..8; NUM_CH > 2 gives TDM.
REQ-004 Parameter BCLK_DIV, default 2: clk cycles per BCLK half-period; >= 1.
REQ-005 Parameter MODE, default I2S_STD: I2S_STD is standard I2S with a one-bit data delay; I2S_LJ is left-justified.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 en_i  in  1  transmitter enable.
REQ-009 data_i  in  NUM_CH*DATA_W  packed frame; channel 0 in the LSBs.
REQ-010 valid_i  in  1  data_i valid.
REQ-011 ready_o  out  1  holding buffer can accept a frame.
REQ-012 bclk_o  out  1  bit clock.
REQ-013 lrclk_o  out  1  word select / frame sync.
REQ-014 sdata_o  out  1  serial data, MSB first.
REQ-015 frame_o  out  1  one-clk pulse at each frame load.
REQ-016 underrun_o  out  1  sticky underrun flag.
REQ-017 underrun_clr_i  in  1  clears underrun_o.

Function
REQ-018 Divider: counter counts 0..BCLK_DIV-1; on wrap, bclk_o toggles; BCLK period = 2*BCLK_DIV clk cycles.
REQ-019 Falling-edge rule: sdata_o and lrclk_o change only on bclk_o falling edges; they are stable across each rising edge.
REQ-020 Bit counter: counts 0..SLOT_W*NUM_CH-1 on each falling edge, then wraps to 0.
REQ-021 Frame load: at the falling edge where the bit counter equals 0, the frame shift register loads from the holding buffer and frame_o pulses for that one clk cycle.
REQ-022 Slot format: each slot carries DATA_W bits MSB first, then SLOT_W-DATA_W zero bits; channel 0 is sent first.
REQ-023 Frame sync: lrclk_o is low for slots 0..NUM_CH/2-1 and high for the remaining slots.
REQ-024 In I2S_STD, lrclk_o transitions one bit period before the first MSB of each slot group, so each slot's MSB appears one BCLK after the lrclk_o edge.
REQ-025 In I2S_LJ, lrclk_o transitions coincident with the first MSB of each slot group.
REQ-026 Handshake: ready_o is the inverse of the buffer-full flag; a frame transfers when valid_i and ready_o are both high at a clk edge.
REQ-027 Buffer full is set on a transfer and cleared by a frame load.
REQ-028 A load that finds the buffer empty transmits an all-zero frame and sets underrun_o.
REQ-029 underrun_o is cleared by underrun_clr_i; a simultaneous set and clear in the same cycle leaves underrun_o set.
REQ-030 Latency: a frame accepted before the falling edge at bit counter 0 is transmitted starting at that edge; otherwise it is transmitted at the next frame start.
REQ-031 en_i low: bclk_o, lrclk_o and sdata_o are held at 0, and the divider and bit counters are held at 0; buffer contents and the handshake remain live.
REQ-032 en_i deasserted mid-frame: the frame in flight is abandoned immediately.
REQ-033 en_i rising: the first falling edge occurs 2*BCLK_DIV clk cycles later; bit counter = 0 at that edge, so a frame load occurs.

Reset
REQ-034 While rst is high, all counters, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o and the buffer-full flag are 0, and ready_o is 1.
REQ-035 Reset mid-frame discards both the buffered frame and the frame in flight.

Structure
REQ-036 Package i2s_pkg holds the mode enum (I2S_STD, I2S_LJ) and a localparam function giving frame bits = SLOT_W*NUM_CH.
REQ-037 Sub-module i2s_clk_div generates bclk_o plus single-cycle rise and fall strobes from BCLK_DIV.
REQ-038 The top level contains the holding buffer, shift register, bit counter and frame-sync logic.

Verification
REQ-039 Defaults at 12.288 MHz: bclk_o period = 4 clk; frame_o period = 256 clk (48 kHz sample rate).
REQ-040 Defaults, I2S_STD, L=0xA5A5A5, R=0x5A5A5A: a sample on every BCLK rise yields lrclk_o low, 1 delay bit, 24 bits of 0xA5A5A5, 8 zeros, then the R slot.
REQ-041 MODE=I2S_LJ, NUM_CH=4, DATA_W=16, SLOT_W=16, ch0..3 = 0x1234/0x5678/0x9ABC/0xDEF0: lrclk_o is low for 32 bits, then high for 32 bits; MSB is coincident with each lrclk_o edge; frame = 64 bits.
REQ-042 valid_i never asserted after reset: the first frame is all zeros, underrun_o = 1, and it stays 1 until underrun_clr_i; a simultaneous underrun and clear leaves it 1.
REQ-043 Back-to-back valid_i: ready_o drops after one transfer and rises in the frame_o cycle; no frame is dropped or repeated over 10 frames.
REQ-044 en_i deasserted at bit 17: outputs are 0 on the next clk; on re-enable, the first falling edge follows after 2*BCLK_DIV clk, with frame_o and MSB of the buffered frame; rst asserted mid-frame gives ready_o = 1 and buffer empty.
